// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants and mode codes.
// The quantizer and the dequant unpacker both use these, so they agree on every shift.
package lenet_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_CONV1 = 2'd1,
        MODE_CONV2 = 2'd2,
        MODE_DONE  = 2'd3
    } mode_e;

    localparam int DATA_BW   = 8;
    localparam int WEIGHT_BW = 4;
    localparam int ACC_BW    = 32;

    localparam int CONV1_WEIGHT_FL   = 3;
    localparam int CONV1_DATA_IN_FL  = 8;
    localparam int CONV1_DATA_OUT_FL = 5;
    localparam int CONV2_WEIGHT_FL   = 5;
    localparam int CONV2_DATA_IN_FL  = 5;
    localparam int CONV2_DATA_OUT_FL = 4;

    localparam int CONV1_SHIFT   = CONV1_WEIGHT_FL + CONV1_DATA_IN_FL - CONV1_DATA_OUT_FL;
    localparam int CONV2_SHIFT   = CONV2_WEIGHT_FL + CONV2_DATA_IN_FL - CONV2_DATA_OUT_FL;
    localparam int CONV1_BIAS_SH = CONV1_DATA_IN_FL;
    localparam int CONV2_BIAS_SH = CONV2_DATA_IN_FL;

    function automatic logic [DATA_BW-1:0] byte_sel(input logic [4*DATA_BW-1:0] w,
                                                     input logic [1:0] i);
        case (i)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/dequant_alu.sv
// Combinational q -> accumulator-scale conversion with bias removal.
// Any mode other than CONV2 uses the CONV1 scaling.
module dequant_alu
    import lenet_pkg::*;
(
    input  logic [DATA_BW-1:0]   q,
    input  logic [WEIGHT_BW-1:0] bias,
    input  mode_e                mode_sel,
    output logic [ACC_BW-1:0]    out_data
);

    logic signed [ACC_BW-1:0] q_ext;
    logic signed [ACC_BW-1:0] b_ext;

    assign q_ext = {{(ACC_BW-DATA_BW){q[DATA_BW-1]}}, q};
    assign b_ext = {{(ACC_BW-WEIGHT_BW){bias[WEIGHT_BW-1]}}, bias};

    always_comb begin
        if (mode_sel == MODE_CONV2) begin
            out_data = (q_ext <<< CONV2_SHIFT) - (b_ext <<< CONV2_BIAS_SH);
        end else begin
            out_data = (q_ext <<< CONV1_SHIFT) - (b_ext <<< CONV1_BIAS_SH);
        end
    end

endmodule

// File: rtl/dequant_unpack.sv
// Unpacks four int8 activations per word into de-quantized 32-bit values, one per cycle.
//   state     | meaning
//   ST_IDLE   | no word held, output register empty
//   ST_UNPACK | word held, byte idx_q is on out_*
module dequant_unpack
    import lenet_pkg::*;
(
    input  logic                 clk,
    input  logic                 srstn,
    input  logic [1:0]           mode,
    input  logic [WEIGHT_BW-1:0] bias_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*DATA_BW-1:0] in_word,
    input  logic                 in_last,
    input  logic [1:0]           in_nbytes,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_BW-1:0]    out_data,
    output logic                 out_last
);

    typedef enum logic {ST_IDLE, ST_UNPACK} state_e;

    state_e                 state_q, state_d;
    logic [4*DATA_BW-1:0]   word_q, word_d;
    logic [WEIGHT_BW-1:0]   bias_q, bias_d;
    logic                   last_q, last_d;
    logic [1:0]             final_idx_q, final_idx_d;
    logic [1:0]             idx_q, idx_d;
    logic                   frame_q, frame_d;
    mode_e                  mode_q, mode_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_BW-1:0]      out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;

    logic                   out_fire, in_fire, at_final, frame_open;
    logic [1:0]             idx_nxt;
    mode_e                  mode_new;
    logic [DATA_BW-1:0]     alu_q;
    logic [WEIGHT_BW-1:0]   alu_bias;
    mode_e                  alu_mode;
    logic [ACC_BW-1:0]      alu_out;

    assign out_fire   = out_valid_q & out_ready;
    assign at_final   = (idx_q == final_idx_q);
    assign in_ready   = srstn & ((state_q == ST_IDLE) | (out_fire & at_final));
    assign in_fire    = in_valid & in_ready;
    assign idx_nxt    = idx_q + 2'd1;
    // A word accepted on the out_last handshake already belongs to the next frame.
    assign frame_open = frame_q & ~(out_fire & out_last_q);
    assign mode_new   = (mode == MODE_CONV2) ? MODE_CONV2 : MODE_CONV1;

    always_comb begin
        alu_q    = byte_sel(word_q, idx_nxt);
        alu_bias = bias_q;
        alu_mode = mode_q;
        if (in_fire) begin
            alu_q    = in_word[DATA_BW-1:0];
            alu_bias = bias_data;
            alu_mode = frame_open ? mode_q : mode_new;
        end
    end

    dequant_alu u_alu (
        .q        (alu_q),
        .bias     (alu_bias),
        .mode_sel (alu_mode),
        .out_data (alu_out)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        bias_d      = bias_q;
        last_d      = last_q;
        final_idx_d = final_idx_q;
        idx_d       = idx_q;
        frame_d     = frame_open;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (in_fire) begin
            state_d     = ST_UNPACK;
            word_d      = in_word;
            bias_d      = bias_data;
            last_d      = in_last;
            final_idx_d = in_last ? (in_nbytes - 2'd1) : 2'd3;
            idx_d       = 2'd0;
            frame_d     = 1'b1;
            mode_d      = alu_mode;
            out_valid_d = 1'b1;
            out_data_d  = alu_out;
            out_last_d  = in_last & (in_nbytes == 2'd1);
        end else if (out_fire) begin
            if (at_final) begin
                state_d     = ST_IDLE;
                idx_d       = 2'd0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                idx_d      = idx_nxt;
                out_data_d = alu_out;
                out_last_d = last_q & (idx_nxt == final_idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            bias_q      <= '0;
            last_q      <= 1'b0;
            final_idx_q <= 2'd3;
            idx_q       <= 2'd0;
            frame_q     <= 1'b0;
            mode_q      <= MODE_CONV1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            bias_q      <= bias_d;
            last_q      <= last_d;
            final_idx_q <= final_idx_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dequant_unpack.sv
// Bench for dequant_unpack: a frame-level reference model fed from accepted words,
// compared against every output handshake, plus literal expectations for known vectors.
module tb_dequant_unpack;

    logic        clk = 1'b0;
    logic        srstn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  bias_data = 4'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = 32'd0;
    logic        in_last = 1'b0;
    logic [1:0]  in_nbytes = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;

    dequant_unpack dut (
        .clk       (clk),
        .srstn     (srstn),
        .mode      (mode),
        .bias_data (bias_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_last   (in_last),
        .in_nbytes (in_nbytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct { int v; bit last; } item_t;
    typedef struct { int v; bit last; int cyc; } obs_t;

    item_t exp_q[$];
    obs_t  obs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    frame_open = 1'b0;
    bit    frame_conv2 = 1'b0;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // q scaled by 2^6 in both layers; bias aligned by 2^8 (CONV1) or 2^5 (CONV2).
    function automatic int expv(input logic [7:0] q, input logic [3:0] b, input bit conv2);
        int qi;
        int bi;
        qi = int'($signed(q));
        bi = int'($signed(b));
        return qi * 64 - bi * (conv2 ? 32 : 256);
    endfunction

    task automatic model_accept(input logic [31:0] w, input logic [3:0] b, input logic [1:0] m,
                                input logic l, input logic [1:0] nb);
        int n;
        logic [31:0] sh;
        item_t it;
        if (!frame_open) begin
            frame_conv2 = (m == 2'd2);
            frame_open  = 1'b1;
        end
        n = l ? ((nb == 2'd0) ? 4 : int'(nb)) : 4;
        for (int k = 0; k < n; k++) begin
            sh = w >> (8 * k);
            it.v = expv(sh[7:0], b, frame_conv2);
            it.last = l && (k == n - 1);
            exp_q.push_back(it);
        end
        if (l) frame_open = 1'b0;
    endtask

    task automatic monitor_loop();
        bit prev_stall = 1'b0;
        logic [31:0] pdata = 32'd0;
        logic plast = 1'b0;
        item_t it;
        obs_t ob;
        forever begin
            @(negedge clk);
            cyc++;
            if (!srstn) begin
                check("in_ready_in_reset", int'(in_ready), 0);
                exp_q.delete();
                frame_open = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (prev_stall) begin
                check("stall_hold_data", int'($signed(out_data)), int'($signed(pdata)));
                check("stall_hold_last", int'(out_last), int'(plast));
            end
            check("in_ready", int'(in_ready),
                  int'((exp_q.size() == 0) || (out_valid && out_ready && exp_q.size() == 1)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    check("out_data", int'($signed(out_data)), it.v);
                    check("out_last", int'(out_last), int'(it.last));
                    ob.v = int'($signed(out_data));
                    ob.last = out_last;
                    ob.cyc = cyc;
                    obs_q.push_back(ob);
                end
            end
            prev_stall = out_valid && !out_ready;
            pdata = out_data;
            plast = out_last;
            if (in_valid && in_ready) model_accept(in_word, bias_data, mode, in_last, in_nbytes);
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] b, input logic [1:0] m,
                             input logic l, input logic [1:0] nb);
        bit ok = 1'b0;
        in_word = w; bias_data = b; mode = m; in_last = l; in_nbytes = nb; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("send_accept_timeout", int'(ok), 1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string name, input int idx, input int v, input bit l);
        if (obs_q.size() > idx) begin
            check(name, obs_q[idx].v, v);
            check({name, "_last"}, int'(obs_q[idx].last), int'(l));
        end else begin
            check({name, "_missing"}, obs_q.size(), idx + 1);
        end
    endtask

    initial begin
        int nw;
        fork
            monitor_loop();
            ready_loop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        @(posedge clk);
        #1;
        srstn = 1'b1;

        check("model_c1_b-1_q1", expv(8'h01, 4'hF, 1'b0), 320);
        check("model_c2_b3_q-2", expv(8'hFE, 4'h3, 1'b1), -224);
        check("model_c2_b0_q127", expv(8'h7F, 4'h0, 1'b1), 8128);

        obs_q.delete();
        send_word(32'h8001FF7F, 4'h0, 2'd1, 1'b1, 2'd0);
        drain();
        check("vec1_count", obs_q.size(), 4);
        check_obs("vec1_b0", 0, 8128, 1'b0);
        check_obs("vec1_b1", 1, -64, 1'b0);
        check_obs("vec1_b2", 2, 64, 1'b0);
        check_obs("vec1_b3", 3, -8192, 1'b1);

        obs_q.delete();
        send_word(32'h00000001, 4'hF, 2'd1, 1'b1, 2'd1);
        send_word(32'h000000FE, 4'h3, 2'd2, 1'b1, 2'd1);
        send_word(32'h0000007F, 4'h0, 2'd2, 1'b1, 2'd1);
        drain();
        check_obs("c1_bm1_q1", 0, 320, 1'b1);
        check_obs("c2_b3_qm2", 1, -224, 1'b1);
        check_obs("c2_b0_q127", 2, 8128, 1'b1);

        obs_q.delete();
        send_word(32'h04030201, 4'h0, 2'd1, 1'b0, 2'd0);
        send_word(32'h08070605, 4'h0, 2'd1, 1'b1, 2'd0);
        drain();
        check("b2b_count", obs_q.size(), 8);
        if (obs_q.size() == 8) check("b2b_no_bubble", obs_q[7].cyc - obs_q[0].cyc, 7);
        check_obs("b2b_v7", 7, 512, 1'b1);

        obs_q.delete();
        send_word(32'h44332211, 4'h0, 2'd1, 1'b1, 2'd2);
        send_word(32'h99999905, 4'h0, 2'd1, 1'b1, 2'd1);
        drain();
        check("nb2_count", obs_q.size(), 3);
        check_obs("nb2_b0", 0, 1088, 1'b0);
        check_obs("nb2_b1", 1, 2176, 1'b1);
        check_obs("nb2_next", 2, 320, 1'b1);

        obs_q.delete();
        send_word(32'h00000000, 4'h1, 2'd1, 1'b0, 2'd0);
        send_word(32'h00000000, 4'h1, 2'd2, 1'b1, 2'd1);
        send_word(32'h00000000, 4'h1, 2'd2, 1'b1, 2'd1);
        drain();
        check_obs("mode_w1", 0, -256, 1'b0);
        check_obs("mode_w2_kept", 4, -256, 1'b1);
        check_obs("mode_w3_new", 5, -32, 1'b1);

        send_word(32'h01020304, 4'h0, 2'd1, 1'b0, 2'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        srstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midword_rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        srstn = 1'b1;
        obs_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check("midword_rst_no_output", obs_q.size(), 0);

        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            nw = $urandom_range(1, 4);
            for (int wi = 0; wi < nw; wi++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_word($urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          (wi == nw - 1), 2'($urandom_range(0, 3)));
            end
        end
        drain();
        rand_ready = 1'b0;
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
